// File: rtl/bp_update_scheduler_if.sv
// Bundle of update, rollback, table-port and status signals for bp_update_scheduler.
// slave: the scheduler side; master: the pipeline/table side that drives it.
interface bp_update_scheduler_if #(
  parameter int unsigned INDEX_WIDTH   = 12,
  parameter int unsigned COUNTER_WIDTH = 2
);
  logic                     PL_stall;
  logic                     upd_valid;
  logic [INDEX_WIDTH-1:0]   upd_index;
  logic                     upd_taken;
  logic                     upd_ready;
  logic                     rb_valid;
  logic [INDEX_WIDTH-1:0]   rb_index;
  logic [COUNTER_WIDTH-1:0] rb_count;
  logic [INDEX_WIDTH-1:0]   tbl_raddr;
  logic [COUNTER_WIDTH-1:0] tbl_rdata;
  logic                     tbl_we;
  logic [INDEX_WIDTH-1:0]   tbl_waddr;
  logic [COUNTER_WIDTH-1:0] tbl_wdata;
  logic                     init_done;
  logic                     busy;

  modport slave (
    input  PL_stall, upd_valid, upd_index, upd_taken, rb_valid, rb_index, rb_count, tbl_rdata,
    output upd_ready, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, init_done, busy
  );

  modport master (
    output PL_stall, upd_valid, upd_index, upd_taken, rb_valid, rb_index, rb_count, tbl_rdata,
    input  upd_ready, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata, init_done, busy
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Single write-port scheduler for a 2-bit pattern-history table: init sweep, FIFO-buffered
// pipelined RMW updates, rollback restore. Define BP_UPD_BYPASS_EN for the empty-FIFO bypass.
module bp_update_scheduler #(
  parameter int unsigned              INDEX_WIDTH   = 12,
  parameter int unsigned              COUNTER_WIDTH = 2,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_INIT  = '0,
  parameter int unsigned              FIFO_DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rst,
  bp_update_scheduler_if.slave bus
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [COUNTER_WIDTH-1:0] CntMax = '1;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [INDEX_WIDTH-1:0] fifo_idx_q [FIFO_DEPTH];
  logic                   fifo_tkn_q [FIFO_DEPTH];

  logic                     wr_vld_q, wr_vld_d;
  logic [INDEX_WIDTH-1:0]   wr_idx_q, wr_idx_d;
  logic                     wr_tkn_q, wr_tkn_d;
  logic                     fwd_vld_q, fwd_vld_d;
  logic [INDEX_WIDTH-1:0]   fwd_idx_q, fwd_idx_d;
  logic [COUNTER_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic                     in_run, fifo_empty, fifo_full, ready;
  logic                     accept, push, pop, byp, wr_fire;
  logic [INDEX_WIDTH-1:0]   head_idx;
  logic                     head_tkn;
  logic [COUNTER_WIDTH-1:0] old_cnt, new_cnt;

  always_comb begin
    in_run     = (state_q == StRun);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    head_idx   = fifo_idx_q[rd_ptr_q[AddrW-1:0]];
    head_tkn   = fifo_tkn_q[rd_ptr_q[AddrW-1:0]];
    // Rollback owns the cycle: no accept, no pop, the in-flight write is dropped.
    ready      = in_run && !fifo_full && !bus.rb_valid;
    accept     = bus.upd_valid && ready;
    pop        = in_run && !fifo_empty && !bus.PL_stall && !bus.rb_valid;
`ifdef BP_UPD_BYPASS_EN
    byp        = accept && fifo_empty && !bus.PL_stall;
`else
    byp        = 1'b0;
`endif
    push       = accept && !byp;
    wr_fire    = in_run && wr_vld_q && !bus.rb_valid;

    // The previous WR op's write lands on the same edge our read sampled, so forward it.
    old_cnt = (fwd_vld_q && (fwd_idx_q == wr_idx_q)) ? fwd_data_q : bus.tbl_rdata;
    if (wr_tkn_q) new_cnt = (old_cnt == CntMax) ? old_cnt : old_cnt + COUNTER_WIDTH'(1);
    else          new_cnt = (old_cnt == '0)     ? old_cnt : old_cnt - COUNTER_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vld_d   = pop || byp;
    wr_idx_d   = pop ? head_idx : bus.upd_index;
    wr_tkn_d   = pop ? head_tkn : bus.upd_taken;
    fwd_vld_d  = wr_fire;
    fwd_idx_d  = wr_idx_q;
    fwd_data_d = new_cnt;

    if (state_q == StInit) begin
      sweep_d = sweep_q + INDEX_WIDTH'(1);
      if (&sweep_q) state_d = StRun;
    end

    if (in_run && bus.rb_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    bus.upd_ready = 1'b0;
    bus.tbl_raddr = '0;
    bus.tbl_we    = 1'b0;
    bus.tbl_waddr = '0;
    bus.tbl_wdata = '0;
    bus.init_done = 1'b0;
    bus.busy      = 1'b1;
    if (!rst) begin
      bus.upd_ready = ready;
      bus.init_done = in_run;
      bus.busy      = !in_run || !fifo_empty || wr_vld_q;
      if (pop)      bus.tbl_raddr = head_idx;
      else if (byp) bus.tbl_raddr = bus.upd_index;
      if (state_q == StInit) begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = sweep_q;
        bus.tbl_wdata = COUNTER_INIT;
      end else if (bus.rb_valid) begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = bus.rb_index;
        bus.tbl_wdata = bus.rb_count;
      end else if (wr_fire) begin
        bus.tbl_we    = 1'b1;
        bus.tbl_waddr = wr_idx_q;
        bus.tbl_wdata = new_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_vld_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_tkn_q   <= 1'b0;
      fwd_vld_q  <= 1'b0;
      fwd_idx_q  <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vld_q   <= wr_vld_d;
      wr_idx_q   <= wr_idx_d;
      wr_tkn_q   <= wr_tkn_d;
      fwd_vld_q  <= fwd_vld_d;
      fwd_idx_q  <= fwd_idx_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_idx_q[wr_ptr_q[AddrW-1:0]] <= bus.upd_index;
      fifo_tkn_q[wr_ptr_q[AddrW-1:0]] <= bus.upd_taken;
    end
  end

endmodule
